// File: rtl/exmem_pkg.sv
// Shared definitions for the EX/MEM pipeline register.
// Contents: store funct3 encodings, the store-size decode, and the packed
// control-bit bundle used on both sides of the register.
package exmem_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef struct packed {
    logic rdsrc;
    logic memtoreg;
    logic memwrite;
    logic memread;
    logic regwrite;
    logic f_regwrite;
    logic is_float;
  } ex_ctrl_t;

  // Access size in bytes from funct3[1:0]; funct3[2] is judged by the caller.
  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    logic [2:0] base;
    base = {1'b0, funct3[1:0]};
    case (base)
      F3_SB:   size_of = 4'd1;
      F3_SH:   size_of = 4'd2;
      F3_SW:   size_of = 4'd4;
      F3_SD:   size_of = 4'd8;
      default: size_of = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/exmem_pipe_reg_store_align_unit.sv
// Store lane alignment: byte strobes, active-low bit mask, shifted data, fault.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: off (byte offset in word), funct3, data (LSB-justified) in;
//        byte_en, web, aligned, fault out.
module store_align_unit
  import exmem_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NBYTE = XLEN / 8,
  localparam int OFFW  = $clog2(NBYTE)
) (
  input  logic [OFFW-1:0]  off,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  data,
  output logic [NBYTE-1:0] byte_en,
  output logic [XLEN-1:0]  web,
  output logic [XLEN-1:0]  aligned,
  output logic             fault
);

  logic [3:0]  sz;
  logic [15:0] mask;
  logic        misalign;

  always_comb begin
    sz       = size_of(funct3);
    // Wide enough that an 8-byte mask does not overflow before truncation.
    mask     = (16'd1 << sz) - 16'd1;
    misalign = (({{(4-OFFW){1'b0}}, off}) & (sz - 4'd1)) != 4'd0;
    fault    = funct3[2] | (sz > 4'(NBYTE)) | misalign;
    byte_en  = fault ? '0 : NBYTE'(mask << off);
    aligned  = fault ? data : (data << {off, 3'b000});
    for (int i = 0; i < XLEN; i++) begin
      web[i] = ~byte_en[i/8];
    end
  end

endmodule

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with store alignment, stall (hold) and flush (bubble).
// Latency: 1 cycle EX->MEM. Backpressure: stall holds every output; flush wins over stall.
// Ports: clk/reset/stall/flush; ex_* EX-stage inputs; mem_* registered MEM-stage outputs.
module exmem_pipe_reg
  import exmem_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int RA_W  = 5,
  localparam int NBYTE = XLEN / 8,
  localparam int OFFW  = $clog2(NBYTE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_alu_out,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic [2:0]       ex_funct3,
  input  logic [RA_W-1:0]  ex_write_addr,
  input  logic [RA_W-1:0]  ex_f_write_addr,
  input  logic             ex_rdsrc,
  input  logic             ex_memtoreg,
  input  logic             ex_memwrite,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             ex_f_regwrite,
  input  logic             ex_is_float,
  output logic             mem_valid,
  output logic [XLEN-1:0]  mem_alu_out,
  output logic [XLEN-1:0]  mem_pc,
  output logic [XLEN-1:0]  mem_store_data,
  output logic [XLEN-1:0]  mem_web,
  output logic [NBYTE-1:0] mem_byte_en,
  output logic             mem_store_fault,
  output logic [2:0]       mem_funct3,
  output logic [RA_W-1:0]  mem_write_addr,
  output logic [RA_W-1:0]  mem_f_write_addr,
  output logic             mem_rdsrc,
  output logic             mem_memtoreg,
  output logic             mem_memread,
  output logic             mem_regwrite,
  output logic             mem_f_regwrite,
  output logic             mem_is_float
);

  ex_ctrl_t         ex_ctrl;
  logic [NBYTE-1:0] al_byte_en;
  logic [XLEN-1:0]  al_web;
  logic [XLEN-1:0]  al_data;
  logic             al_fault;

  assign ex_ctrl = '{rdsrc: ex_rdsrc, memtoreg: ex_memtoreg, memwrite: ex_memwrite,
                     memread: ex_memread, regwrite: ex_regwrite,
                     f_regwrite: ex_f_regwrite, is_float: ex_is_float};

  store_align_unit #(.XLEN(XLEN)) u_align (
    .off     (ex_alu_out[OFFW-1:0]),
    .funct3  (ex_funct3),
    .data    (ex_store_data),
    .byte_en (al_byte_en),
    .web     (al_web),
    .aligned (al_data),
    .fault   (al_fault)
  );

  logic             valid_q, valid_d;
  ex_ctrl_t         ctrl_q, ctrl_d;
  logic             fault_q, fault_d;
  logic [NBYTE-1:0] byte_en_q, byte_en_d;
  logic [XLEN-1:0]  web_q, web_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  sdata_q, sdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [RA_W-1:0]  waddr_q, waddr_d;
  logic [RA_W-1:0]  fwaddr_q, fwaddr_d;

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    fault_d   = fault_q;
    byte_en_d = byte_en_q;
    web_d     = web_q;
    alu_d     = alu_q;
    pc_d      = pc_q;
    sdata_d   = sdata_q;
    funct3_d  = funct3_q;
    waddr_d   = waddr_q;
    fwaddr_d  = fwaddr_q;
    if (flush || (!stall && !ex_valid)) begin
      // Bubble: kill control only; strobes are masked off by ctrl_q.memwrite.
      valid_d = 1'b0;
      ctrl_d  = '0;
      fault_d = 1'b0;
    end else if (!stall) begin
      valid_d         = 1'b1;
      ctrl_d          = ex_ctrl;
      // memwrite in MEM means "store actually commits"; a faulting store does not.
      ctrl_d.memwrite = ex_memwrite & ~al_fault;
      fault_d         = ex_memwrite & al_fault;
      byte_en_d       = al_byte_en;
      web_d           = al_web;
      alu_d           = ex_alu_out;
      pc_d            = ex_pc;
      sdata_d         = ex_memwrite ? al_data : ex_store_data;
      funct3_d        = ex_funct3;
      waddr_d         = ex_write_addr;
      fwaddr_d        = ex_f_write_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      fault_q   <= 1'b0;
      byte_en_q <= '0;
      web_q     <= '1;
      alu_q     <= '0;
      pc_q      <= '0;
      sdata_q   <= '0;
      funct3_q  <= '0;
      waddr_q   <= '0;
      fwaddr_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      fault_q   <= fault_d;
      byte_en_q <= byte_en_d;
      web_q     <= web_d;
      alu_q     <= alu_d;
      pc_q      <= pc_d;
      sdata_q   <= sdata_d;
      funct3_q  <= funct3_d;
      waddr_q   <= waddr_d;
      fwaddr_q  <= fwaddr_d;
    end
  end

  assign mem_valid        = valid_q;
  assign mem_alu_out      = alu_q;
  assign mem_pc           = pc_q;
  assign mem_store_data   = sdata_q;
  assign mem_web          = web_q | {XLEN{~ctrl_q.memwrite}};
  assign mem_byte_en      = byte_en_q & {NBYTE{ctrl_q.memwrite}};
  assign mem_store_fault  = fault_q;
  assign mem_funct3       = funct3_q;
  assign mem_write_addr   = waddr_q;
  assign mem_f_write_addr = fwaddr_q;
  assign mem_rdsrc        = ctrl_q.rdsrc;
  assign mem_memtoreg     = ctrl_q.memtoreg;
  assign mem_memread      = ctrl_q.memread;
  assign mem_regwrite     = ctrl_q.regwrite;
  assign mem_f_regwrite   = ctrl_q.f_regwrite;
  assign mem_is_float     = ctrl_q.is_float;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
module tb_exmem_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ex_valid;
  logic [63:0] alu, pc, sd;
  logic [2:0]  f3;
  logic [4:0]  wa, fwa;
  logic        rdsrc, m2r, mw, mr, rw, frw, isf;

  logic        v32, flt32, rdsrc32, m2r32, mr32, rw32, frw32, isf32;
  logic [31:0] alu32, pc32, sd32, web32;
  logic [3:0]  be32;
  logic [2:0]  f332;
  logic [4:0]  wa32, fwa32;

  logic        v64, flt64, rdsrc64, m2r64, mr64, rw64, frw64, isf64;
  logic [63:0] alu64, pc64, sd64, web64;
  logic [7:0]  be64;
  logic [2:0]  f364;
  logic [4:0]  wa64, fwa64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exmem_pipe_reg #(.XLEN(32), .RA_W(5)) dut32 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(alu[31:0]), .ex_pc(pc[31:0]), .ex_store_data(sd[31:0]), .ex_funct3(f3),
    .ex_write_addr(wa), .ex_f_write_addr(fwa), .ex_rdsrc(rdsrc), .ex_memtoreg(m2r),
    .ex_memwrite(mw), .ex_memread(mr), .ex_regwrite(rw), .ex_f_regwrite(frw), .ex_is_float(isf),
    .mem_valid(v32), .mem_alu_out(alu32), .mem_pc(pc32), .mem_store_data(sd32),
    .mem_web(web32), .mem_byte_en(be32), .mem_store_fault(flt32), .mem_funct3(f332),
    .mem_write_addr(wa32), .mem_f_write_addr(fwa32), .mem_rdsrc(rdsrc32),
    .mem_memtoreg(m2r32), .mem_memread(mr32), .mem_regwrite(rw32),
    .mem_f_regwrite(frw32), .mem_is_float(isf32)
  );

  exmem_pipe_reg #(.XLEN(64), .RA_W(5)) dut64 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(alu), .ex_pc(pc), .ex_store_data(sd), .ex_funct3(f3),
    .ex_write_addr(wa), .ex_f_write_addr(fwa), .ex_rdsrc(rdsrc), .ex_memtoreg(m2r),
    .ex_memwrite(mw), .ex_memread(mr), .ex_regwrite(rw), .ex_f_regwrite(frw), .ex_is_float(isf),
    .mem_valid(v64), .mem_alu_out(alu64), .mem_pc(pc64), .mem_store_data(sd64),
    .mem_web(web64), .mem_byte_en(be64), .mem_store_fault(flt64), .mem_funct3(f364),
    .mem_write_addr(wa64), .mem_f_write_addr(fwa64), .mem_rdsrc(rdsrc64),
    .mem_memtoreg(m2r64), .mem_memread(mr64), .mem_regwrite(rw64),
    .mem_f_regwrite(frw64), .mem_is_float(isf64)
  );

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [2:0] fn, input logic [63:0] a,
                        input logic [63:0] p, input logic [63:0] d,
                        input logic w, input logic r, input logic [4:0] rd);
    ex_valid = v; f3 = fn; alu = a; pc = p; sd = d; mw = w; mr = r; wa = rd;
    m2r = r; rw = r; fwa = rd + 5'd1; rdsrc = 1'b0; frw = 1'b0; isf = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ex(1'b1, 3'b010, 64'h40, 64'h80, 64'h1234, 1'b1, 1'b1, 5'd3);
    step();
    checks++; if (v32 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", v32); end
    checks++; if (web32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_web32: got %h want ffffffff", web32); end
    checks++; if (web64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rst_web64: got %h want all ones", web64); end
    checks++; if ({be32, flt32, alu32, pc32, sd32, wa32, rw32, mr32} !== '0) begin errors++; $display("FAIL rst_zero32: got nonzero outputs be=%h alu=%h pc=%h sd=%h", be32, alu32, pc32, sd32); end
    reset = 1'b0;
    set_ex(1'b0, 3'b010, 64'h40, 64'h80, 64'h1234, 1'b1, 1'b1, 5'd3);
    step();
    checks++; if (v32 !== 1'b0 || be32 !== 4'h0 || web32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bubble_load: got v=%b be=%h web=%h want 0/0/ffffffff", v32, be32, web32); end
    checks++; if (pc32 !== 32'h0) begin errors++; $display("FAIL bubble_pc_hold: got %h want 0", pc32); end
  endtask

  task automatic test_sb32();
    set_ex(1'b1, 3'b000, 64'h1003, 64'h100, 64'hAB, 1'b1, 1'b0, 5'd0);
    step();
    checks++; if (be32 !== 4'b1000) begin errors++; $display("FAIL sb32_be: got %b want 1000", be32); end
    checks++; if (web32 !== 32'h00FF_FFFF) begin errors++; $display("FAIL sb32_web: got %h want 00ffffff", web32); end
    checks++; if (sd32 !== 32'hAB00_0000) begin errors++; $display("FAIL sb32_data: got %h want ab000000", sd32); end
    checks++; if (flt32 !== 1'b0 || v32 !== 1'b1 || pc32 !== 32'h100) begin errors++; $display("FAIL sb32_misc: got flt=%b v=%b pc=%h want 0/1/100", flt32, v32, pc32); end
    checks++; if (be64 !== 8'h08 || sd64 !== 64'hAB00_0000) begin errors++; $display("FAIL sb64_off3: got be=%h sd=%h want 08/ab000000", be64, sd64); end
  endtask

  task automatic test_faults32();
    set_ex(1'b1, 3'b001, 64'h1001, 64'h104, 64'hAB, 1'b1, 1'b0, 5'd0);
    step();
    checks++; if (flt32 !== 1'b1 || web32 !== 32'hFFFF_FFFF || be32 !== 4'h0) begin errors++; $display("FAIL sh_mis: got flt=%b web=%h be=%h want 1/ffffffff/0", flt32, web32, be32); end
    checks++; if (alu32 !== 32'h1001 || sd32 !== 32'hAB || v32 !== 1'b1) begin errors++; $display("FAIL sh_mis_fields: got alu=%h sd=%h v=%b want 1001/ab/1", alu32, sd32, v32); end
    set_ex(1'b1, 3'b010, 64'h1002, 64'h108, 64'h55, 1'b1, 1'b0, 5'd0);
    step();
    checks++; if (flt32 !== 1'b1 || be32 !== 4'h0) begin errors++; $display("FAIL sw_mis: got flt=%b be=%h want 1/0", flt32, be32); end
    set_ex(1'b1, 3'b011, 64'h1000, 64'h10C, 64'h55, 1'b1, 1'b0, 5'd0);
    step();
    checks++; if (flt32 !== 1'b1 || web32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sd32: got flt=%b web=%h want 1/ffffffff", flt32, web32); end
    checks++; if (flt64 !== 1'b0 || be64 !== 8'hFF) begin errors++; $display("FAIL sd64_ok: got flt=%b be=%h want 0/ff", flt64, be64); end
    set_ex(1'b1, 3'b100, 64'h1000, 64'h110, 64'h55, 1'b1, 1'b0, 5'd0);
    step();
    checks++; if (flt32 !== 1'b1 || flt64 !== 1'b1 || be64 !== 8'h00) begin errors++; $display("FAIL f3hi: got flt32=%b flt64=%b be64=%h want 1/1/00", flt32, flt64, be64); end
    // A load with a would-be-misaligned address must not raise a store fault.
    set_ex(1'b1, 3'b010, 64'h1001, 64'h114, 64'h77, 1'b0, 1'b1, 5'd4);
    step();
    checks++; if (flt32 !== 1'b0 || be32 !== 4'h0 || web32 !== 32'hFFFF_FFFF || sd32 !== 32'h77) begin errors++; $display("FAIL load_nostore: got flt=%b be=%h web=%h sd=%h want 0/0/ffffffff/77", flt32, be32, web32, sd32); end
    checks++; if (mr32 !== 1'b1 || m2r32 !== 1'b1 || wa32 !== 5'd4 || fwa32 !== 5'd5) begin errors++; $display("FAIL load_ctrl: got mr=%b m2r=%b wa=%0d fwa=%0d want 1/1/4/5", mr32, m2r32, wa32, fwa32); end
  endtask

  task automatic test_store64();
    set_ex(1'b1, 3'b010, 64'h2004, 64'h200, 64'hDEAD_BEEF, 1'b1, 1'b0, 5'd0);
    step();
    checks++; if (be64 !== 8'hF0) begin errors++; $display("FAIL sw64_be: got %h want f0", be64); end
    checks++; if (sd64 !== 64'hDEAD_BEEF_0000_0000) begin errors++; $display("FAIL sw64_data: got %h want deadbeef00000000", sd64); end
    checks++; if (web64 !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL sw64_web: got %h want 00000000ffffffff", web64); end
    checks++; if (be32 !== 4'hF || sd32 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw32_off0: got be=%h sd=%h want f/deadbeef", be32, sd32); end
    set_ex(1'b1, 3'b011, 64'h2008, 64'h204, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 5'd0);
    step();
    checks++; if (be64 !== 8'hFF || web64 !== 64'h0 || sd64 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL sd64: got be=%h web=%h sd=%h want ff/0/0123456789abcdef", be64, web64, sd64); end
  endtask

  task automatic test_stall();
    set_ex(1'b1, 3'b000, 64'h1003, 64'h300, 64'hAB, 1'b1, 1'b0, 5'd7);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 3'b010, 64'h2000 + 64'(i * 4), 64'h400, 64'h55, 1'b1, 1'b1, 5'd9);
      step();
      checks++; if (be32 !== 4'b1000 || sd32 !== 32'hAB00_0000 || pc32 !== 32'h300 || wa32 !== 5'd7 || v32 !== 1'b1 || rw32 !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got be=%h sd=%h pc=%h wa=%0d v=%b want 8/ab000000/300/7/1", i, be32, sd32, pc32, wa32, v32);
      end
    end
    stall = 1'b0;
    step();
    checks++; if (be32 !== 4'hF || sd32 !== 32'h55 || pc32 !== 32'h400 || alu32 !== 32'h2008 || rw32 !== 1'b1) begin errors++; $display("FAIL stall_release: got be=%h sd=%h pc=%h alu=%h want f/55/400/2008", be32, sd32, pc32, alu32); end
  endtask

  task automatic test_stall_flush();
    set_ex(1'b1, 3'b000, 64'h3001, 64'h500, 64'hCC, 1'b1, 1'b1, 5'd11);
    stall = 1'b1; flush = 1'b1;
    step();
    checks++; if (v32 !== 1'b0 || web32 !== 32'hFFFF_FFFF || be32 !== 4'h0 || flt32 !== 1'b0 || rw32 !== 1'b0) begin errors++; $display("FAIL flush_ctrl: got v=%b web=%h be=%h flt=%b want 0/ffffffff/0/0", v32, web32, be32, flt32); end
    checks++; if (pc32 !== 32'h400 || alu32 !== 32'h2008 || sd32 !== 32'h55 || wa32 !== 5'd9) begin errors++; $display("FAIL flush_data_hold: got pc=%h alu=%h sd=%h wa=%0d want 400/2008/55/9", pc32, alu32, sd32, wa32); end
    checks++; if (v64 !== 1'b0 || web64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL flush64: got v=%b web=%h want 0/all ones", v64, web64); end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_ex(1'b1, 3'b010, 64'h4004, 64'h600, 64'h99, 1'b1, 1'b0, 5'd2);
    step();
    stall = 1'b1;
    step();
    checks++; if (be32 !== 4'hF || pc32 !== 32'h600) begin errors++; $display("FAIL pre_reset_hold: got be=%h pc=%h want f/600", be32, pc32); end
    reset = 1'b1;
    step();
    checks++; if (v32 !== 1'b0 || web32 !== 32'hFFFF_FFFF || be32 !== 4'h0 || pc32 !== 32'h0 || alu32 !== 32'h0 || sd32 !== 32'h0) begin errors++; $display("FAIL reset_mid_stall: got v=%b web=%h be=%h pc=%h alu=%h sd=%h want 0/ffffffff/0/0/0/0", v32, web32, be32, pc32, alu32, sd32); end
    reset = 1'b0; stall = 1'b0;
    set_ex(1'b0, 3'b010, 64'h4008, 64'h700, 64'h99, 1'b1, 1'b0, 5'd2);
    step();
    checks++; if (v32 !== 1'b0 || web32 !== 32'hFFFF_FFFF || pc32 !== 32'h0) begin errors++; $display("FAIL post_reset_bubble: got v=%b web=%h pc=%h want 0/ffffffff/0", v32, web32, pc32); end
  endtask

  initial begin
    #2;
    test_reset();
    test_sb32();
    test_faults32();
    test_store64();
    test_stall();
    test_stall_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the integer/float core. It latches EX-stage results and control, and aligns store data to the data-memory lane. It generates an active-low bit-write mask plus active-high byte strobes, and flags misaligned or unsupported stores. Unlike the previous-generation stage register, it supports XLEN 32/64, stall (hold), flush (bubble) and a valid bit.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
RA_W, 5, register-address width (integer and float files)
NBYTE, XLEN/8, derived localparam; lanes per word; not overridable

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
stall  in  1  hold all MEM-side state this cycle
flush  in  1  insert bubble into MEM this cycle
ex_valid  in  1  EX stage holds a real instruction
ex_alu_out  in  XLEN  ALU result / effective address
ex_pc  in  XLEN  instruction PC
ex_store_data  in  XLEN  rs2 data for stores (LSB-justified)
ex_funct3  in  3  instruction funct3
ex_write_addr  in  RA_W  integer rd
ex_f_write_addr  in  RA_W  float rd
ex_rdsrc, ex_memtoreg, ex_memwrite, ex_memread, ex_regwrite, ex_f_regwrite, ex_is_float  in  1 each  EX control bits
mem_valid  out  1  MEM stage holds a real instruction
mem_alu_out, mem_pc  out  XLEN  registered copies
mem_store_data  out  XLEN  lane-aligned store data
mem_web  out  XLEN  active-low bit write mask (0 = write bit)
mem_byte_en  out  NBYTE  active-high byte strobes (consistent with mem_web)
mem_store_fault  out  1  store suppressed: misaligned or unsupported width
mem_funct3, mem_write_addr, mem_f_write_addr  out  3/RA_W/RA_W  registered copies
mem_rdsrc, mem_memtoreg, mem_memread, mem_regwrite, mem_f_regwrite, mem_is_float  out  1 each  registered control

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state updates on posedge clk only.
- Priority per edge: reset > flush > stall > load.
- Reset: every output is 0, except mem_web, which is all ones.
- Flush, or load with ex_valid=0 (bubble): mem_valid, all control outputs, mem_byte_en and mem_store_fault go to 0; mem_web goes to all ones; data/address/pc fields hold their previous values.
- Stall (flush=0): every output holds, including mem_valid. A stall never creates or drops an instruction.
- Load (ex_valid=1, no stall/flush): latency 1 cycle. mem_valid=1; all pass-through fields are copied.
- Store path (ex_memwrite=1):
  - off = ex_alu_out[log2(NBYTE)-1:0]; size from funct3[1:0]: 00 = 1 byte, 01 = 2, 10 = 4, 11 = 8.
  - Legal store: funct3[2]=0, size <= NBYTE, and off a multiple of size. Result: mem_byte_en = ((1<<size)-1) << off; mem_web bit i = ~mem_byte_en[i/8]; mem_store_data = ex_store_data << (8*off), truncated to XLEN.
  - Illegal store (funct3[2]=1, SD with XLEN=32, or misaligned): mem_store_fault=1, mem_byte_en=0, mem_web all ones, mem_store_data=ex_store_data unshifted, mem_memwrite-derived strobes suppressed. Other fields load normally so the trap unit sees pc/address.
- Non-store load: mem_web all ones, mem_byte_en 0, mem_store_fault 0, mem_store_data = ex_store_data.
- SW with XLEN=64 at off=4: bytes 7..4 enabled, data << 32.
- Reset asserted during stall or flush: reset wins; next cycle behaves per the inputs then present.

Decomposition:
- Package exmem_pkg: funct3 store constants (F3_SB/SH/SW/SD), function size_of(funct3), typedef ex_ctrl_t (packed struct of the seven control bits) used at both port groups.
- Sub-module store_align_unit (combinational, parametrised XLEN): inputs off, funct3, data; outputs byte_en, web, aligned data, fault. The top level holds only registers and priority logic.

Test Plan:
- XLEN=32, SB, alu_out=0x1003, store_data=0x000000AB -> next cycle mem_byte_en=4'b1000, mem_web=0x00FFFFFF, mem_store_data=0xAB000000, mem_store_fault=0, mem_valid=1.
- XLEN=32, SH at 0x1001 -> mem_store_fault=1, mem_web=0xFFFFFFFF, mem_byte_en=0, mem_alu_out=0x1001; SW at 0x1002 -> fault; SD (funct3=011) at 0x1000 -> fault.
- XLEN=64, SW at 0x2004, data 0xDEADBEEF -> mem_byte_en=8'hF0, mem_store_data=0xDEADBEEF00000000; SD at 0x2008 -> byte_en=8'hFF, mem_web=0.
- Load SB, then stall=1 for 3 cycles with changing EX inputs -> all outputs are frozen at the SB values; on stall release the new EX values load next edge.
- stall=1 and flush=1 together with a valid store on EX -> mem_valid=0, mem_web all ones, byte_en=0, data fields unchanged.
- Assert reset mid-stall after a valid store -> next edge all outputs 0 and mem_web all ones; ex_valid=0 load afterwards keeps mem_valid=0.
